// File: rtl/write_back_stage_pkg.sv
// Shared write-back definitions: register map, regfile types and store FSM states.
// Flags and PC live in the architectural register file alongside the GPRs.
package write_back_stage_pkg;

    localparam int NR = 4;
    localparam int IW = $clog2(NR);

    localparam int unsigned PC    = 2;
    localparam int unsigned Flags = 3;

    typedef logic [2:0]            regind_t;
    typedef logic [31:0]           regval_t;
    typedef regval_t [NR-1:0]      regfile_t;

    localparam regfile_t ZeroRegFile = '0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STORE = 1'b1
    } wb_state_t;

    // Index 0 is hardwired to zero and indices past NR do not exist.
    function automatic logic idx_ok(input logic [3:0] i);
        return (i != 4'd0) && (i < 4'(NR));
    endfunction

endpackage

// File: rtl/write_back_store_fsm.sv
// Stalling store sequencer: latches address/data and holds upstream
// until the memory accepts the write.
module write_back_store_fsm
    import write_back_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        mem_wait_i,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_data_o,
    output logic        mem_write_o,
    output logic        hold_o,
    output logic        done_o
);

    wb_state_t   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = STORE;
                    addr_d  = addr_i;
                    data_d  = data_i;
                end
            end
            STORE: begin
                if (!mem_wait_i) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Driven straight from state so a reset drops the request immediately.
    assign mem_write_o   = (state_q == STORE);
    assign hold_o        = (state_q == STORE);
    assign done_o        = (state_q == STORE) && !mem_wait_i;
    assign mem_address_o = addr_q;
    assign mem_data_o    = data_q;

endmodule

// File: rtl/write_back_stage.sv
// Final pipeline stage: retires into the register file, drives bypass
// feedback, sequences stores and flags PC redirects back to fetch.
module write_back_stage
    import write_back_stage_pkg::*;
#(
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flow_is_valid_i,
    output logic            flow_hold_o,
    input  logic            ex_has_flushed_i,
    input  logic            ex_is_writing_memory_i,
    input  logic [2:0]      ex_destination_register_i,
    input  logic [31:0]     ex_destination_value_i,
    input  logic            ex_has_upper_value_i,
    input  logic [31:0]     ex_upper_value_i,
    input  logic [3:0]      ex_flags_i,
    input  logic [31:0]     ex_pc_i,
    input  logic [31:0]     ex_adjustment_value_i,
    output logic            fb_is_valid_o,
    output logic [31:0]     fb_value_o,
    output logic [31:0]     fb_upper_value_o,
    output logic [2:0]      fb_index_o,
    output logic            fb_has_upper_value_o,
    output logic            wf_has_flushed_o,
    output logic [NR*32-1:0] registers_o,
    output logic [31:0]     mem_address_o,
    output logic [31:0]     mem_data_o,
    output logic            mem_write_o,
    input  logic            mem_wait_i
);

    regfile_t regs_q, regs_d;
    logic     flush_q, flush_d;

    logic       hold;
    logic       store_done;
    logic       accept;
    logic       commit;
    logic       store_go;
    logic [3:0] dst_idx;
    logic [3:0] up_idx;
    logic       dst_ok;
    logic       up_ok;
    logic       pc_wr;

    assign accept   = flow_is_valid_i && !hold;
    assign commit   = accept && !ex_has_flushed_i
                      && !ex_is_writing_memory_i;
    assign store_go = accept && !ex_has_flushed_i
                      && ex_is_writing_memory_i;

    assign dst_idx = {1'b0, ex_destination_register_i};
    assign up_idx  = dst_idx + 4'd1;
    assign dst_ok  = idx_ok(dst_idx);
    assign up_ok   = ex_has_upper_value_i && idx_ok(up_idx);
    assign pc_wr   = (dst_ok && dst_idx == 4'(PC))
                     || (up_ok && up_idx == 4'(PC));

    write_back_store_fsm u_store_fsm (
        .clock         (clock),
        .reset_n       (reset_n),
        .start_i       (store_go),
        .addr_i        (ex_adjustment_value_i),
        .data_i        (ex_destination_value_i),
        .mem_wait_i    (mem_wait_i),
        .mem_address_o (mem_address_o),
        .mem_data_o    (mem_data_o),
        .mem_write_o   (mem_write_o),
        .hold_o        (hold),
        .done_o        (store_done)
    );

    // Implicit Flags/PC updates first so explicit destinations override them.
    always_comb begin
        regs_d  = regs_q;
        flush_d = 1'b0;
        if (commit || store_done) begin
            regs_d[Flags] = {28'b0, ex_flags_i};
            regs_d[PC]    = ex_pc_i + PC_STEP;
        end
        if (commit) begin
            if (dst_ok) begin
                regs_d[dst_idx[IW-1:0]] = ex_destination_value_i;
            end
            if (up_ok) begin
                regs_d[up_idx[IW-1:0]] = ex_upper_value_i;
            end
            flush_d = pc_wr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q  <= ZeroRegFile;
            flush_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            flush_q <= flush_d;
        end
    end

    assign flow_hold_o          = hold;
    assign wf_has_flushed_o     = flush_q;
    assign registers_o          = regs_q;
    assign fb_is_valid_o        = commit && (dst_idx != 4'd0);
    assign fb_value_o           = ex_destination_value_i;
    assign fb_upper_value_o     = ex_upper_value_i;
    assign fb_index_o           = ex_destination_register_i;
    assign fb_has_upper_value_o = ex_has_upper_value_i;

endmodule
